// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port program/data memory between the CPU sequencer (priority)
// and a host/debug port, stealing one CPU cycle when the host has waited MAX_WAIT cycles.
module mem_port_arbiter #(
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_en,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    output logic [7:0]    stall_cnt,
    output logic          proto_err
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic {OBSERVE, STEAL} state_t;

    state_t        r_state;
    logic [WW-1:0] r_wait_cnt;
    logic          r_cpu_en;
    logic          r_host_rvalid;
    logic [DW-1:0] r_host_rdata;
    logic [7:0]    r_stall_cnt;
    logic          r_proto_err;

    logic          w_cpu_req;
    logic          w_host_sel;
    logic [WW-1:0] w_wait_inc;

    assign w_cpu_req  = cpu_rd | cpu_wr;
    assign w_wait_inc = (r_wait_cnt == WW'(MAX_WAIT)) ? r_wait_cnt : r_wait_cnt + WW'(1);

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        w_host_sel = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        if (r_state == OBSERVE) begin
            if (w_cpu_req) begin
                // Simultaneous read and write: the write wins.
                mem_wr = cpu_wr;
                mem_rd = cpu_rd & ~cpu_wr;
            end else begin
                w_host_sel = host_req;
            end
        end else begin
            w_host_sel = host_req;
        end
        if (w_host_sel) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_wr    = host_we;
            mem_rd    = ~host_we;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state       <= OBSERVE;
            r_wait_cnt    <= '0;
            r_cpu_en      <= 1'b1;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
            r_stall_cnt   <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            r_host_rvalid <= w_host_sel & ~host_we;
            if (w_host_sel && !host_we) begin
                r_host_rdata <= mem_rdata;
            end
            case (r_state)
                OBSERVE: begin
                    if (cpu_rd && cpu_wr) begin
                        r_proto_err <= 1'b1;
                    end
                    if (host_req && !w_host_sel) begin
                        r_wait_cnt <= w_wait_inc;
                        if (w_wait_inc == WW'(MAX_WAIT)) begin
                            r_state  <= STEAL;
                            r_cpu_en <= 1'b0;
                        end
                    end else begin
                        r_wait_cnt <= '0;
                    end
                end
                STEAL: begin
                    r_wait_cnt <= '0;
                    r_state    <= OBSERVE;
                    r_cpu_en   <= 1'b1;
                    if (r_stall_cnt != 8'hFF) begin
                        r_stall_cnt <= r_stall_cnt + 8'd1;
                    end
                end
                default: r_state <= OBSERVE;
            endcase
        end
    end

    assign cpu_rdata   = mem_rdata;
    assign cpu_en      = r_cpu_en;
    assign host_gnt    = w_host_sel;
    assign host_rdata  = r_host_rdata;
    assign host_rvalid = r_host_rvalid;
    assign stall_cnt   = r_stall_cnt;
    assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small behavioural memory.
module tb_mem_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_;
    logic          cpu_rd, cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_en;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] mem_rdata;
    logic [7:0]    stall_cnt;
    logic          proto_err;

    logic [DW-1:0] mem [32];
    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_(rst_),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_en(cpu_en),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ = 0;
        step();
        rst_ = 1;
        step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7);
        mem[3] = 8'hA5;
        mem[1] = 8'h11;
        rst_ = 1;
        idle_inputs();
        #2;
        do_reset();

        // Reset then idle
        for (int c = 0; c < 3; c++) begin
            #2;
            check("idle cpu_en", cpu_en, 1);
            check("idle strobes", {mem_rd, mem_wr}, 0);
            check("idle gnt", host_gnt, 0);
            check("idle stall", stall_cnt, 0);
            check("idle rvalid", host_rvalid, 0);
            step();
        end

        // Host read while CPU idle
        host_req = 1; host_we = 0; host_addr = 5'h03;
        #2;
        check("hrd gnt", host_gnt, 1);
        check("hrd mem_rd", mem_rd, 1);
        check("hrd mem_wr", mem_wr, 0);
        check("hrd addr", mem_addr, 5'h03);
        step();
        host_req = 0;
        #2;
        check("hrd rvalid", host_rvalid, 1);
        check("hrd rdata", host_rdata, 8'hA5);
        step();
        #2;
        check("hrd rvalid pulse", host_rvalid, 0);
        check("hrd rdata hold", host_rdata, 8'hA5);
        step();

        // CPU reads cycles 0,1,3; host write fits into idle cycle 2
        host_req = 1; host_we = 1; host_addr = 5'h1F; host_wdata = 8'h3C;
        cpu_rd = 1; cpu_addr = 5'h01;
        for (int c = 0; c < 4; c++) begin
            cpu_rd = (c != 2);
            if (c == 3) host_req = 0;
            #2;
            check("hwr gnt", host_gnt, (c == 2) ? 1 : 0);
            check("hwr cpu_en", cpu_en, 1);
            if (c == 2) begin
                check("hwr mem_wr", mem_wr, 1);
                check("hwr wdata", mem_wdata, 8'h3C);
                check("hwr addr", mem_addr, 5'h1F);
            end else begin
                check("hwr cpu rd", {mem_rd, mem_wr}, 2'b10);
                check("hwr cpu addr", mem_addr, 5'h01);
                check("hwr cpu rdata", cpu_rdata, 8'h11);
            end
            step();
        end
        cpu_rd = 0;
        #2;
        check("hwr stall", stall_cnt, 0);
        check("hwr rvalid", host_rvalid, 0);
        check("hwr mem", mem[31], 8'h3C);

        // CPU saturates memory; host read forces a steal after 4 cycles
        do_reset();
        cpu_rd = 1; cpu_addr = 5'h01;
        host_req = 1; host_we = 0; host_addr = 5'h03;
        for (int c = 0; c < 4; c++) begin
            #2;
            check("steal wait gnt", host_gnt, 0);
            check("steal wait en", cpu_en, 1);
            step();
        end
        #2;
        check("steal en", cpu_en, 0);
        check("steal gnt", host_gnt, 1);
        check("steal addr", mem_addr, 5'h03);
        check("steal strobes", {mem_rd, mem_wr}, 2'b10);
        step();
        host_req = 0;
        #2;
        check("post en", cpu_en, 1);
        check("post rvalid", host_rvalid, 1);
        check("post rdata", host_rdata, 8'hA5);
        check("post stall", stall_cnt, 1);
        check("post gnt", host_gnt, 0);
        step();

        // Host request held 12 cycles: steals at 4 and 9 only
        do_reset();
        cpu_rd = 1; cpu_addr = 5'h01;
        host_req = 1; host_we = 0; host_addr = 5'h03;
        for (int c = 0; c < 12; c++) begin
            #2;
            check("hold gnt", host_gnt, (c == 4 || c == 9) ? 1 : 0);
            check("hold en", cpu_en, (c == 4 || c == 9) ? 0 : 1);
            step();
        end
        host_req = 0;
        #2;
        check("hold stall", stall_cnt, 2);

        // Host drops req in the steal cycle: cycle still stolen, no access
        step();
        host_req = 1;
        for (int c = 0; c < 4; c++) begin
            #2;
            check("drop wait gnt", host_gnt, 0);
            step();
        end
        host_req = 0;
        #2;
        check("drop en", cpu_en, 0);
        check("drop gnt", host_gnt, 0);
        check("drop strobes", {mem_rd, mem_wr}, 0);
        step();
        #2;
        check("drop stall", stall_cnt, 3);
        check("drop rvalid", host_rvalid, 0);
        check("drop en back", cpu_en, 1);

        // Protocol error: read and write together
        cpu_rd = 1; cpu_wr = 1; cpu_addr = 5'h0A; cpu_wdata = 8'h5E;
        #2;
        check("perr strobes", {mem_rd, mem_wr}, 2'b01);
        step();
        cpu_rd = 0; cpu_wr = 0;
        #2;
        check("perr set", proto_err, 1);
        check("perr mem", mem[10], 8'h5E);
        step(); step();
        #2;
        check("perr sticky", proto_err, 1);

        // Reset in the middle of a host wait
        cpu_rd = 1; cpu_addr = 5'h01;
        host_req = 1; host_we = 0; host_addr = 5'h03;
        step(); step(); step();
        rst_ = 0;
        host_req = 0;
        #2;
        check("rst gnt", host_gnt, 0);
        check("rst perr", proto_err, 0);
        check("rst stall", stall_cnt, 0);
        check("rst en", cpu_en, 1);
        step();
        rst_ = 1;
        check("rst rvalid", host_rvalid, 0);
        step();
        host_req = 1;
        for (int c = 0; c < 5; c++) begin
            #2;
            check("rearm gnt", host_gnt, (c == 4) ? 1 : 0);
            check("rearm en", cpu_en, (c == 4) ? 0 : 1);
            step();
        end
        host_req = 0;
        cpu_rd = 0;
        #2;
        check("rearm stall", stall_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
